// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: DIGITS-wide operands plus carry-in, one-cycle latency.
// Optional input-digit range checker on err is enabled by defining BCD_ADDER_CHECK_EN.
module bcd_adder #(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  out_valid,
  output logic                  err
);

  // Handshake: an operand set is accepted on every rising edge where in_valid is
  // high and rst is low; out_valid pulses for one cycle after each acceptance.
  // There is no ready: each new result simply overwrites the previous one.

  logic [DIGITS:0]       w_carry;
  logic [4*DIGITS-1:0]   w_sum;
  logic                  w_err;

  logic [4*DIGITS-1:0]   r_sum;
  logic                  r_cout;
  logic                  r_valid;

  assign w_carry[0] = cin;

  // Carry ripples through every digit in the same cycle.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [4:0] w_z;
    logic       w_k;

    assign w_z = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]} + {4'b0000, w_carry[gi]};
    // Same as w_z > 9, also valid for non-BCD input digits up to 31.
    assign w_k = w_z[4] | (w_z[3] & (w_z[2] | w_z[1]));
    assign w_sum[4*gi +: 4] = w_z[3:0] + (w_k ? 4'd6 : 4'd0);
    assign w_carry[gi+1] = w_k;
  end

`ifdef BCD_ADDER_CHECK_EN
  logic [DIGITS-1:0] w_bad;
  logic              r_err;

  for (genvar gj = 0; gj < DIGITS; gj++) begin : g_check
    assign w_bad[gj] = (a[4*gj +: 4] > 4'd9) | (b[4*gj +: 4] > 4'd9);
  end

  assign w_err = |w_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_valid) begin
      r_err <= w_err;
    end
  end

  assign err = r_err;
`else
  assign w_err = 1'b0;
  assign err   = w_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[DIGITS];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_bcd_adder.sv
// Directed bench for bcd_adder: 1-, 2- and 4-digit instances sharing clock and reset.
// Expected err follows whether BCD_ADDER_CHECK_EN is defined for the build.
module tb_bcd_adder;

`ifdef BCD_ADDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst;

  logic        v1, cin1, cout1, ov1, err1;
  logic [3:0]  a1, b1, sum1;
  logic        v2, cin2, cout2, ov2, err2;
  logic [7:0]  a2, b2, sum2;
  logic        v4, cin4, cout4, ov4, err4;
  logic [15:0] a4, b4, sum4;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_c_q[$];

  bcd_adder #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .out_valid(ov1), .err(err1)
  );

  bcd_adder #(.DIGITS(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(v2), .a(a2), .b(b2), .cin(cin2),
    .sum(sum2), .cout(cout2), .out_valid(ov2), .err(err2)
  );

  bcd_adder #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .out_valid(ov4), .err(err4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive1(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; v1 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive4(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (sum1 !== 4'h0) begin n_errors++; $display("FAIL reset_sum1: got %h expected 0", sum1); end
    n_checks++; if (cout1 !== 1'b0) begin n_errors++; $display("FAIL reset_cout1: got %b expected 0", cout1); end
    n_checks++; if (ov1 !== 1'b0) begin n_errors++; $display("FAIL reset_ov1: got %b expected 0", ov1); end
    n_checks++; if (err1 !== 1'b0) begin n_errors++; $display("FAIL reset_err1: got %b expected 0", err1); end
    n_checks++; if (sum4 !== 16'h0 || ov4 !== 1'b0) begin n_errors++; $display("FAIL reset_d4: got sum %h ov %b expected 0 0", sum4, ov4); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive1(4'h3, 4'h4, 1'b0);
    n_checks++; if (sum1 !== 4'h7) begin n_errors++; $display("FAIL basic_sum: got %h expected 7", sum1); end
    n_checks++; if (cout1 !== 1'b0) begin n_errors++; $display("FAIL basic_cout: got %b expected 0", cout1); end
    n_checks++; if (ov1 !== 1'b1) begin n_errors++; $display("FAIL basic_ov: got %b expected 1", ov1); end
    n_checks++; if (err1 !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b expected 0", err1); end
    idle_all();
  endtask

  task automatic test_carry();
    drive1(4'h8, 4'h9, 1'b0);
    n_checks++; if (sum1 !== 4'h7 || cout1 !== 1'b1) begin n_errors++; $display("FAIL carry_8p9: got %h c%b expected 7 c1", sum1, cout1); end
    drive1(4'h9, 4'h9, 1'b1);
    n_checks++; if (sum1 !== 4'h9 || cout1 !== 1'b1) begin n_errors++; $display("FAIL carry_9p9p1: got %h c%b expected 9 c1", sum1, cout1); end
    n_checks++; if (ov1 !== 1'b1) begin n_errors++; $display("FAIL carry_b2b_ov: got %b expected 1", ov1); end
    drive1(4'h2, 4'h5, 1'b1);
    n_checks++; if (sum1 !== 4'h8 || cout1 !== 1'b0) begin n_errors++; $display("FAIL carry_cin: got %h c%b expected 8 c0", sum1, cout1); end
    idle_all();
    @(posedge clk); #1;
    n_checks++; if (ov1 !== 1'b0) begin n_errors++; $display("FAIL carry_ov_drop: got %b expected 0", ov1); end
  endtask

  task automatic test_non_bcd();
    drive1(4'hA, 4'h1, 1'b0);
    n_checks++; if (sum1 !== 4'h1 || cout1 !== 1'b1) begin n_errors++; $display("FAIL nonbcd_a_p1: got %h c%b expected 1 c1", sum1, cout1); end
    n_checks++; if (err1 !== CHK) begin n_errors++; $display("FAIL nonbcd_err_a: got %b expected %b", err1, CHK); end
    drive1(4'hC, 4'h2, 1'b0);
    n_checks++; if (sum1 !== 4'h4 || cout1 !== 1'b1) begin n_errors++; $display("FAIL nonbcd_c_p2: got %h c%b expected 4 c1", sum1, cout1); end
    drive1(4'hF, 4'hF, 1'b1);
    n_checks++; if (sum1 !== 4'h5 || cout1 !== 1'b1) begin n_errors++; $display("FAIL nonbcd_f_f_1: got %h c%b expected 5 c1", sum1, cout1); end
    drive1(4'h2, 4'hB, 1'b0);
    n_checks++; if (err1 !== CHK) begin n_errors++; $display("FAIL nonbcd_err_b: got %b expected %b", err1, CHK); end
    drive1(4'h2, 4'h3, 1'b0);
    n_checks++; if (err1 !== 1'b0 || sum1 !== 4'h5) begin n_errors++; $display("FAIL nonbcd_err_clear: got err %b sum %h expected 0 5", err1, sum1); end
    idle_all();
  endtask

  task automatic test_multi_digit();
    drive4(16'h9999, 16'h0001, 1'b0);
    n_checks++; if (sum4 !== 16'h0000 || cout4 !== 1'b1) begin n_errors++; $display("FAIL md_9999: got %h c%b expected 0000 c1", sum4, cout4); end
    n_checks++; if (ov4 !== 1'b1) begin n_errors++; $display("FAIL md_ov: got %b expected 1", ov4); end
    drive4(16'h1234, 16'h5678, 1'b0);
    n_checks++; if (sum4 !== 16'h6912 || cout4 !== 1'b0) begin n_errors++; $display("FAIL md_1234: got %h c%b expected 6912 c0", sum4, cout4); end
    drive4(16'h00A0, 16'h0000, 1'b0);
    n_checks++; if (sum4 !== 16'h0100 || cout4 !== 1'b0) begin n_errors++; $display("FAIL md_nonbcd: got %h c%b expected 0100 c0", sum4, cout4); end
    n_checks++; if (err4 !== CHK) begin n_errors++; $display("FAIL md_err: got %b expected %b", err4, CHK); end
    drive4(16'h4999, 16'h5000, 1'b1);
    n_checks++; if (sum4 !== 16'h0000 || cout4 !== 1'b1) begin n_errors++; $display("FAIL md_cin_ripple: got %h c%b expected 0000 c1", sum4, cout4); end
    idle_all();
  endtask

  task automatic test_reset_priority();
    drive1(4'hA, 4'h1, 1'b0);
    @(negedge clk);
    rst = 1'b1; a1 = 4'h5; b1 = 4'h5; cin1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (sum1 !== 4'h0 || cout1 !== 1'b0) begin n_errors++; $display("FAIL rstpri_sum: got %h c%b expected 0 c0", sum1, cout1); end
    n_checks++; if (ov1 !== 1'b0 || err1 !== 1'b0) begin n_errors++; $display("FAIL rstpri_flags: got ov %b err %b expected 0 0", ov1, err1); end
    @(negedge clk);
    rst = 1'b0;
    a1 = 4'h3; b1 = 4'h4; cin1 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (sum1 !== 4'h7 || ov1 !== 1'b1) begin n_errors++; $display("FAIL rstpri_reload: got %h ov %b expected 7 1", sum1, ov1); end
    @(negedge clk);
    v1 = 1'b0; a1 = 4'h9; b1 = 4'h9; cin1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (sum1 !== 4'h7 || cout1 !== 1'b0 || ov1 !== 1'b0) begin
        n_errors++; $display("FAIL hold_%0d: got %h c%b ov %b expected 7 c0 ov 0", i, sum1, cout1, ov1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int da, db, tot;
    logic [7:0] exp_s;
    logic exp_c;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      b2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      cin2 = 1'($urandom_range(0, 1));
      v2 = 1'b1;
      da = int'(a2[7:4]) * 10 + int'(a2[3:0]);
      db = int'(b2[7:4]) * 10 + int'(b2[3:0]);
      tot = da + db + int'(cin2);
      exp_q.push_back({4'((tot / 10) % 10), 4'(tot % 10)});
      exp_c_q.push_back(tot >= 100);
      @(posedge clk); #1;
      exp_s = exp_q.pop_front();
      exp_c = exp_c_q.pop_front();
      n_checks++; if (sum2 !== exp_s || cout2 !== exp_c || ov2 !== 1'b1) begin
        n_errors++; $display("FAIL b2b_%0d: got %h c%b ov %b expected %h c%b ov 1", n, sum2, cout2, ov2, exp_s, exp_c);
      end
    end
    idle_all();
    @(posedge clk); #1;
    n_checks++; if (ov2 !== 1'b0) begin n_errors++; $display("FAIL b2b_ov_end: got %b expected 0", ov2); end
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_non_bcd();
    test_multi_digit();
    test_reset_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
